// File: rtl/mod5_rr_arbiter.sv
// Round-robin arbiter for five requesters with a mod-5 priority pointer,
// registered one-hot grants, a per-grant hold limit and a one-cycle turnaround.
module mod5_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

  logic [1:0]         state, state_nxt;
  logic [2:0]         ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [2:0]         gnt_id_nxt;
  logic               gnt_valid_nxt;
  logic               timeout_nxt;

  logic               found;
  logic [2:0]         sel;
  logic [3:0]         idx;

  // First requester at or after ptr, scanning with mod-5 wrap.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!found && req[3'(idx)]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt     = S_GRANT;
          gnt_nxt       = NUM_REQ'(1) << sel;
          gnt_id_nxt    = sel;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = HOLD_W'(1);
          ptr_nxt       = (sel == LAST_ID) ? 3'd0 : sel + 3'd1;
        end else begin
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        if (!req[gnt_id]) begin
          state_nxt     = S_RECOVER;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
        end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
          state_nxt     = S_RECOVER;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          timeout_nxt   = 1'b1;
        end else begin
          hold_cnt_nxt  = hold_cnt + HOLD_W'(1);
        end
      end
      S_RECOVER: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt     = S_IDLE;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule
